// File: rtl/hamming_encoder.sv
// Registered Hamming (12,8) encoder: data at non-power-of-two positions, parity at 1/2/4/8.
// One-cycle latency, one word per cycle; codeword holds while in_valid is low.
module hamming_encoder #(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [8:1]  D,
  output logic [12:1] hammingCode,
  output logic        out_valid
);

  logic [12:1]       data_placed;
  logic [3:0][12:1]  grp_bits;
  logic [3:0]        parity;
  logic [12:1]       code_d;
  logic [12:1]       code_q;
  logic              valid_q;

  always_comb begin
    data_placed     = '0;
    data_placed[3]  = D[1];
    data_placed[5]  = D[2];
    data_placed[6]  = D[3];
    data_placed[7]  = D[4];
    data_placed[9]  = D[5];
    data_placed[10] = D[6];
    data_placed[11] = D[7];
    data_placed[12] = D[8];
  end

  // Parity bit k covers every position whose index has bit k set; parity slots hold 0 here.
  genvar gi, gp;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_group
      for (gp = 1; gp <= 12; gp++) begin : g_pos
        if (((gp >> gi) & 1) != 0) begin : g_in
          assign grp_bits[gi][gp] = data_placed[gp];
        end else begin : g_out
          assign grp_bits[gi][gp] = 1'b0;
        end
      end
      assign parity[gi] = (^grp_bits[gi]) ^ ODD_PARITY;
    end
  endgenerate

  always_comb begin
    code_d    = data_placed;
    code_d[1] = parity[0];
    code_d[2] = parity[1];
    code_d[4] = parity[2];
    code_d[8] = parity[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        code_q <= code_d;
      end
    end
  end

  assign hammingCode = code_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Self-checking bench for hamming_encoder: directed vectors, streaming, random, exhaustive
// syndrome checks, async reset; even and odd parity instances run side by side.
module tb_hamming_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [8:1]  D;
  logic [12:1] code_e;
  logic [12:1] code_o;
  logic        valid_e;
  logic        valid_o;

  int checks;
  int failures;
  logic [12:1] exp_e;
  logic [12:1] exp_o;

  hamming_encoder #(.ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .D(D),
    .hammingCode(code_e), .out_valid(valid_e)
  );

  hamming_encoder #(.ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .D(D),
    .hammingCode(code_o), .out_valid(valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: place data bits in order at non-power-of-two positions, then choose the
  // parity bits so the XOR of the indices of all set bits (the syndrome) becomes zero.
  function automatic logic [12:1] ref_encode(input logic [7:0] d, input bit odd);
    logic [12:1] cw;
    logic [3:0]  syn;
    int          di;
    cw  = '0;
    syn = '0;
    di  = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[di];
        di++;
      end
    end
    for (int p = 1; p <= 12; p++) begin
      if (cw[p]) syn = syn ^ p[3:0];
    end
    cw[1] = syn[0] ^ odd;
    cw[2] = syn[1] ^ odd;
    cw[4] = syn[2] ^ odd;
    cw[8] = syn[3] ^ odd;
    return cw;
  endfunction

  function automatic logic [3:0] syndrome(input logic [12:1] cw);
    logic [3:0] syn;
    syn = '0;
    for (int p = 1; p <= 12; p++) begin
      if (cw[p]) syn = syn ^ p[3:0];
    end
    return syn;
  endfunction

  function automatic logic [7:0] extract(input logic [12:1] cw);
    logic [7:0] d;
    int         di;
    d  = '0;
    di = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cw[p];
        di++;
      end
    end
    return d;
  endfunction

  task automatic check(input string tag, input logic [12:1] obs, input logic [12:1] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input logic v);
    check({tag, "_code_even"}, code_e, exp_e);
    check({tag, "_code_odd"}, code_o, exp_o);
    check({tag, "_valid_even"}, {11'd0, valid_e}, {11'd0, v});
    check({tag, "_valid_odd"}, {11'd0, valid_o}, {11'd0, v});
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] d);
    in_valid = v;
    D        = d;
    @(posedge clk);
    #1;
    if (v) begin
      exp_e = ref_encode(d, 1'b0);
      exp_o = ref_encode(d, 1'b1);
    end
    check_outputs(tag, v);
    $display("step %s valid=%0b D=%h even=%h odd=%h", tag, v, d, code_e, code_o);
  endtask

  initial begin
    logic [7:0]  stream [16];
    logic [12:1] flipped;
    logic [7:0]  rd;
    logic        rv;

    checks   = 0;
    failures = 0;
    exp_e    = '0;
    exp_o    = '0;
    stream   = '{8'hA1, 8'hA2, 8'hAD, 8'hAE, 8'h99, 8'h9A, 8'h95, 8'h96,
                 8'h61, 8'h62, 8'h6D, 8'h6E, 8'h59, 8'h5A, 8'h55, 8'h56};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    D        = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_held", 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;

    // Directed vectors against fixed constants as well as the model
    step("vec_A1", 1'b1, 8'hA1);
    check("const_A1", code_e, 12'hA0D);
    check("const_A1_odd", code_o, 12'hA86);
    step("vec_A2", 1'b1, 8'hA2);
    check("const_A2", code_e, 12'hA13);
    step("vec_56", 1'b1, 8'h56);
    check("const_56", code_e, 12'h531);
    step("vec_00", 1'b1, 8'h00);
    check("const_00", code_e, 12'h000);
    check("const_00_odd", code_o, 12'h08B);
    step("vec_FF", 1'b1, 8'hFF);
    check("const_FF", code_e, 12'hF77);

    // Back-to-back streaming, then idle with D wiggling
    for (int i = 0; i < 16; i++) begin
      step("stream", 1'b1, stream[i]);
      check("stream_syn", {8'd0, syndrome(code_e)}, 12'd0);
      check("stream_data", {4'd0, extract(code_e)}, {4'd0, stream[i]});
    end
    step("idle0", 1'b0, 8'h3C);
    check("idle_hold", code_e, 12'h531);
    step("idle1", 1'b0, 8'hC3);
    check("idle_hold2", code_e, 12'h531);

    // Random mix of valid and idle cycles
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom_range(0, 255));
      rv = 1'($urandom_range(0, 1));
      step("random", rv, rd);
    end

    // Exhaustive: syndrome, data recovery, single-bit error location
    for (int v = 0; v < 256; v++) begin
      step("exh", 1'b1, v[7:0]);
      check("exh_syn_even", {8'd0, syndrome(code_e)}, 12'd0);
      check("exh_syn_odd", {8'd0, syndrome(code_o)}, 12'h00F);
      check("exh_data", {4'd0, extract(code_e)}, {4'd0, v[7:0]});
      for (int p = 1; p <= 12; p++) begin
        flipped    = code_e;
        flipped[p] = ~flipped[p];
        check("exh_flip", {8'd0, syndrome(flipped)}, 12'(p));
      end
    end

    // Asynchronous reset between edges with a word just captured and another in flight
    step("pre_rst", 1'b1, 8'h5A);
    in_valid = 1'b1;
    D        = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    exp_e = '0;
    exp_o = '0;
    check_outputs("rst_async", 1'b0);
    @(posedge clk);
    #1;
    check_outputs("rst_hold", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step("post_rst_idle", 1'b0, 8'h33);
    step("post_rst_word", 1'b1, 8'hA1);
    check("post_rst_const", code_e, 12'hA0D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
